// File: rtl/tbcm_crc_stream_checker.sv
// tbcm_crc_stream_checker: streaming CRC frame checker with a per-frame pass/fail result channel; failed-frame counter enabled by TBCM_CRC_STREAM_CHECKER_ERROR_COUNT_EN
package tbcm_crc_pkg;
  typedef enum logic [1:0] {TBCM_CRC_8, TBCM_CRC_16, TBCM_CRC_32} tbcm_crc_type;
  function automatic int crc_width(tbcm_crc_type t);
    return t == TBCM_CRC_8 ? 8 : t == TBCM_CRC_16 ? 16 : 32;
  endfunction
  function automatic logic [31:0] crc_poly(tbcm_crc_type t);
    return t == TBCM_CRC_8 ? 32'h07 : t == TBCM_CRC_16 ? 32'h1021 : 32'h04C11DB7;
  endfunction
endpackage

module tbcm_crc_stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter tbcm_crc_pkg::tbcm_crc_type CRC_TYPE = tbcm_crc_pkg::TBCM_CRC_32,
  parameter int COUNT_WIDTH = 16,
  localparam int CRC_WIDTH = tbcm_crc_pkg::crc_width(CRC_TYPE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_last,
  output logic                   o_result_valid,
  input  logic                   i_result_ready,
  output logic                   o_crc_ok,
  output logic [CRC_WIDTH-1:0]   o_crc_residue,
  output logic [COUNT_WIDTH-1:0] o_beat_count,
  output logic [COUNT_WIDTH-1:0] o_error_count
);
  localparam logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(tbcm_crc_pkg::crc_poly(CRC_TYPE));
  if (DATA_WIDTH < CRC_WIDTH) begin : g_width_check
    $error("DATA_WIDTH must be >= CRC width");
  end
  // MSB-first polynomial fold of one beat: returns d(x) * x^CRC_WIDTH mod P
  function automatic logic [CRC_WIDTH-1:0] crc_get(input logic [DATA_WIDTH-1:0] d);
    logic [CRC_WIDTH-1:0] c;
    c = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      c = (c << 1) ^ ((c[CRC_WIDTH-1] ^ d[i]) ? POLY : '0);
    return c;
  endfunction
  typedef enum logic [1:0] {IDLE, FRAME, RESULT} state_t;
  state_t                 state_q, state_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d, residue_q, residue_d, crc_n;
  logic                   ok_q, ok_d, acc, fin;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, beats_q, beats_d, cnt_inc;
  assign o_ready        = state_q != RESULT || i_result_ready;
  assign o_result_valid = state_q == RESULT;
  assign o_crc_ok       = ok_q;
  assign o_crc_residue  = residue_q;
  assign o_beat_count   = beats_q;
  assign acc     = i_valid && o_ready;
  assign fin     = acc && i_last;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign crc_n   = crc_get(i_data ^ (DATA_WIDTH'(crc_q) << (DATA_WIDTH - CRC_WIDTH)));
  // next state: a last beat always lands in RESULT, so a consumed result is replaced without a bubble
  always_comb begin
    state_d   = fin ? RESULT : acc ? FRAME : (state_q == RESULT && i_result_ready) ? IDLE : state_q;
    crc_d     = fin ? '0 : acc ? crc_n : crc_q;
    cnt_d     = fin ? '0 : acc ? cnt_inc : cnt_q;
    residue_d = fin ? crc_n : residue_q;
    ok_d      = fin ? crc_n == '0 : ok_q;
    beats_d   = fin ? cnt_inc : beats_q;
  end
  // state and result registers; reset discards any partial frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      crc_q     <= '0;
      cnt_q     <= '0;
      residue_q <= '0;
      ok_q      <= 1'b0;
      beats_q   <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      residue_q <= residue_d;
      ok_q      <= ok_d;
      beats_q   <= beats_d;
    end
  end
`ifdef TBCM_CRC_STREAM_CHECKER_ERROR_COUNT_EN
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  // saturating count of frames whose residue is nonzero
  always_comb err_d = (fin && crc_n != '0 && !(&err_q)) ? err_q + 1'b1 : err_q;
  // error counter register
  always_ff @(posedge i_clk) err_q <= i_rst ? '0 : err_d;
  assign o_error_count = err_q;
`else
  assign o_error_count = '0;
`endif
endmodule
